lc3_mem_arbiter: RTL

- Arbitrates a single data-memory port between the LC-3 instruction-fetch stage and the memory-access stage.
- Sequences each access: grant, address/data drive, fixed-latency wait, data capture and one-cycle acknowledge.
- Sits between the fetch/memory-access units and the dmem port (dmem_addr/dmem_din/dmem_rd/dmem_dout).

---
 rtl/lc3_mem_arbiter_if.sv | 46 ++++
 rtl/lc3_mem_arbiter.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/lc3_mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// lc3_mem_arbiter_if
//   Bundles the requester handshakes (fetch and memory-access) and the data
//   memory port seen by lc3_mem_arbiter.
//
//   Handshake contract: a requester raises *_req with its address (and write
//   data / ma_we for memory access) stable, and holds them until it sees the
//   matching *_ack, which is a one-cycle pulse.  *_rdata is valid while *_ack
//   is high and holds its value afterwards.  The requester must drop *_req in
//   the ack cycle, otherwise a new transaction is started.
//
//   Modports:
//     slave  - the arbiter's view (takes requests, drives the memory port)
//     master - the environment's view (requesters plus memory)
//   dbg_state exposes the arbiter FSM state (0=IDLE, 1=WAIT, 2=DONE).
// -----------------------------------------------------------------------------
interface lc3_mem_arbiter_if;
    logic        if_req;
    logic [15:0] if_addr;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        ma_req;
    logic        ma_we;
    logic [15:0] ma_addr;
    logic [15:0] ma_wdata;
    logic [15:0] ma_rdata;
    logic        ma_ack;
    logic [15:0] mem_addr;
    logic [15:0] mem_din;
    logic        mem_rd;
    logic        mem_en;
    logic [15:0] mem_dout;
    logic [1:0]  dbg_state;

    modport slave (
        input  if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_dout,
        output if_rdata, if_ack, ma_rdata, ma_ack,
        output mem_addr, mem_din, mem_rd, mem_en, dbg_state
    );

    modport master (
        output if_req, if_addr, ma_req, ma_we, ma_addr, ma_wdata, mem_dout,
        input  if_rdata, if_ack, ma_rdata, ma_ack,
        input  mem_addr, mem_din, mem_rd, mem_en, dbg_state
    );
endinterface

// File: rtl/lc3_mem_arbiter.sv
// -----------------------------------------------------------------------------
// lc3_mem_arbiter
//   Shares one data-memory port between the LC-3 fetch stage and the
//   memory-access stage.  One transaction at a time:
//     IDLE : pick a winner, register address/data/direction, pulse mem_en
//     WAIT : count MEM_LAT cycles; on the last one capture mem_dout (reads)
//     DONE : winner's ack is high for exactly this cycle, then back to IDLE
//
//   Ports:
//     clk  - clock
//     rst  - synchronous, active-low reset (aborts any access, no ack)
//     bus  - lc3_mem_arbiter_if.slave: if_*/ma_* requester handshakes,
//            mem_addr/mem_din/mem_rd/mem_en/mem_dout memory port, dbg_state
//
//   Parameters:
//     MEM_LAT - cycles from the mem_en cycle to the mem_dout sample edge (1..15)
//     RST_RD  - mem_rd level in reset and idle (1 = read)
//
//   Build option:
//     LC3_MEM_ARB_RR_EN - when defined, contention is resolved round-robin
//                         (the requester not granted last wins); otherwise
//                         memory access always beats fetch.
// -----------------------------------------------------------------------------
module lc3_mem_arbiter #(
    parameter int unsigned MEM_LAT = 2,
    parameter logic        RST_RD  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    lc3_mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] din_q, din_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] ma_rdata_q, ma_rdata_d;
    logic        rd_q, rd_d;
    logic        en_q, en_d;
    logic        if_ack_q, if_ack_d;
    logic        ma_ack_q, ma_ack_d;
    logic        win_ma_q, win_ma_d;   // 1 = current transaction belongs to ma
    logic        grant_ma;             // arbitration result, meaningful in IDLE

`ifdef LC3_MEM_ARB_RR_EN
    logic rr_last_ma_q, rr_last_ma_d;  // 1 = ma was granted last
    // Under contention the side that was not granted last wins.
    assign grant_ma = bus.ma_req && (!bus.if_req || !rr_last_ma_q);
`else
    assign grant_ma = bus.ma_req;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        din_d      = din_q;
        if_rdata_d = if_rdata_q;
        ma_rdata_d = ma_rdata_q;
        rd_d       = rd_q;
        en_d       = 1'b0;
        if_ack_d   = 1'b0;
        ma_ack_d   = 1'b0;
        win_ma_d   = win_ma_q;
`ifdef LC3_MEM_ARB_RR_EN
        rr_last_ma_d = rr_last_ma_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.ma_req) begin
                    win_ma_d = grant_ma;
                    if (grant_ma) begin
                        addr_d = bus.ma_addr;
                        din_d  = bus.ma_wdata;
                        rd_d   = !bus.ma_we;
                    end else begin
                        addr_d = bus.if_addr;
                        rd_d   = 1'b1;       // fetch is always a read
                    end
                    en_d    = 1'b1;
                    cnt_d   = LAT_LOAD;
                    state_d = WAIT;
`ifdef LC3_MEM_ARB_RR_EN
                    rr_last_ma_d = grant_ma;
`endif
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (rd_q) begin
                        if (win_ma_q) ma_rdata_d = bus.mem_dout;
                        else          if_rdata_d = bus.mem_dout;
                    end
                    if (win_ma_q) ma_ack_d = 1'b1;
                    else          if_ack_d = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            DONE: begin
                // Requests are not looked at here; the requester drops req now.
                rd_d    = RST_RD;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= 16'd0;
            din_q      <= 16'd0;
            if_rdata_q <= 16'd0;
            ma_rdata_q <= 16'd0;
            rd_q       <= RST_RD;
            en_q       <= 1'b0;
            if_ack_q   <= 1'b0;
            ma_ack_q   <= 1'b0;
            win_ma_q   <= 1'b0;
`ifdef LC3_MEM_ARB_RR_EN
            rr_last_ma_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            din_q      <= din_d;
            if_rdata_q <= if_rdata_d;
            ma_rdata_q <= ma_rdata_d;
            rd_q       <= rd_d;
            en_q       <= en_d;
            if_ack_q   <= if_ack_d;
            ma_ack_q   <= ma_ack_d;
            win_ma_q   <= win_ma_d;
`ifdef LC3_MEM_ARB_RR_EN
            rr_last_ma_q <= rr_last_ma_d;
`endif
        end
    end

    assign bus.mem_addr  = addr_q;
    assign bus.mem_din   = din_q;
    assign bus.mem_rd    = rd_q;
    assign bus.mem_en    = en_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.ma_rdata  = ma_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.ma_ack    = ma_ack_q;
    assign bus.dbg_state = state_q;

endmodule
